// File: rtl/aes_inv_iter.sv
// Iterative AES-128 inverse cipher: one inverse round per enabled clock edge,
// using the encryptor's round-key array and byte order (byte 0 = bits [127:120]).
module aes_inv_iter #(
  parameter int NR = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                valid_i,
  output logic                ready_o,
  input  logic [127:0]        ciphertext_i,
  input  logic [NR:0][127:0]  round_key_i,
  output logic                valid_o,
  output logic [127:0]        plaintext_o
);

  localparam logic [0:255][7:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  typedef enum logic {IDLE, ROUND} fsm_t;

  fsm_t         fsm_reg;
  logic [3:0]   rnd_reg;
  logic [127:0] state_reg;
  logic [127:0] rk_cur;
  logic [127:0] round_out;
  logic [7:0]   isr_b [16];
  logic [7:0]   isb_b [16];
  logic [7:0]   ark_b [16];
  logic [7:0]   imc_b [16];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Multiply by a constant whose bits select a, 2a, 4a and 8a.
  function automatic logic [7:0] gmul_c(input logic [7:0] a, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return (c[3] ? x8 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^
           (c[1] ? x2 : 8'h00) ^ (c[0] ? a : 8'h00);
  endfunction

  assign ready_o = (fsm_reg == IDLE);
  assign rk_cur  = round_key_i[rnd_reg];

  genvar gi, gj;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_byte
      // Row r of the state rotates right by r columns.
      localparam int ROW = gi % 4;
      localparam int COL = gi / 4;
      localparam int SRC = ROW + 4 * ((COL - ROW + 4) % 4);
      assign isr_b[gi] = state_reg[127 - 8*SRC -: 8];
      assign isb_b[gi] = INV_SBOX[isr_b[gi]];
      assign ark_b[gi] = isb_b[gi] ^ rk_cur[127 - 8*gi -: 8];
      assign round_out[127 - 8*gi -: 8] = (rnd_reg == 4'd0) ? ark_b[gi] : imc_b[gi];
    end

    for (gi = 0; gi < 4; gi++) begin : g_col
      for (gj = 0; gj < 4; gj++) begin : g_row
        assign imc_b[4*gi + gj] = gmul_c(ark_b[4*gi + gj],           4'he) ^
                                  gmul_c(ark_b[4*gi + (gj + 1) % 4], 4'hb) ^
                                  gmul_c(ark_b[4*gi + (gj + 2) % 4], 4'hd) ^
                                  gmul_c(ark_b[4*gi + (gj + 3) % 4], 4'h9);
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_reg     <= IDLE;
      rnd_reg     <= 4'd0;
      state_reg   <= '0;
      plaintext_o <= '0;
      valid_o     <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (en) begin
        case (fsm_reg)
          IDLE: begin
            if (valid_i) begin
              state_reg <= ciphertext_i ^ round_key_i[NR];
              rnd_reg   <= 4'(NR - 1);
              fsm_reg   <= ROUND;
            end
          end
          ROUND: begin
            state_reg <= round_out;
            if (rnd_reg == 4'd0) begin
              plaintext_o <= round_out;
              valid_o     <= 1'b1;
              fsm_reg     <= IDLE;
            end else begin
              rnd_reg <= rnd_reg - 4'd1;
            end
          end
          default: fsm_reg <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/aes_inv_iter.md
Name: aes_inv_iter

Overview:
- Iterative AES-128 inverse cipher (decryptor) as specified in FIPS-197.
- Performs one inverse round per enabled clock cycle and accepts one block per 11 cycles.
- Sits on the receive path opposite the pipelined encryptor.
- Uses the same expanded round-key array, same en/valid conventions and the same byte ordering, so ciphertext from the encryptor decrypts bit-exactly.

Parameters:
NR, 10, number of rounds; only 10 (AES-128) supported, other values are illegal.

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  reset; asynchronous, active-low.
en  input  1  global enable; when 0, all registers except valid_o hold.
valid_i  input  1  ciphertext_i is valid this cycle.
ready_o  output  1  block can accept a new ciphertext.
ciphertext_i  input  128  input block; byte 0 = bits [127:120], column-major state.
round_key_i  input  128 x [10:0]  encryption round keys; [0] = cipher key, [10] = last round key.
valid_o  output  1  one-cycle pulse; plaintext_o holds a new result.
plaintext_o  output  128  decrypted block; holds its value until the next result.

Behaviour:
- Reset (async assert, sync release): FSM=IDLE, round counter=0, state register=0, plaintext_o=0, valid_o=0, ready_o=1.
- FSM states: IDLE, ROUND. ready_o = (FSM==IDLE) and is combinational from the FSM.
- Accept: on an edge with en=1, valid_i=1 and FSM==IDLE:
  - state <= ciphertext_i ^ round_key_i[10]
  - rnd <= 9, FSM <= ROUND
- valid_i while ready_o=0, or while en=0, is ignored; nothing is queued and the producer must hold or resend.
- ROUND, edge with en=1: state <= f(state, rnd), where f applies, in order:
  - InvShiftRows (row r rotated right by r bytes)
  - InvSubBytes (16 parallel inverse S-box lookups)
  - AddRoundKey with round_key_i[rnd]
  - InvMixColumns (coefficients 0e,0b,0d,09 over GF(2^8), poly 0x11b), skipped when rnd==0
- While rnd!=0: rnd <= rnd-1.
- When rnd==0 (final round), on that edge:
  - plaintext_o <= f(state, 0), valid_o <= 1, FSM <= IDLE
  - state register is not required to be updated.
- ROUND, edge with en=0: state, rnd and FSM hold; no progress.
- valid_o is cleared on every edge where it is not being set, regardless of en, so it is exactly one cycle wide.
- Latency with en held at 1:
  - accept at edge k; valid_o high between edge k+10 and k+11.
  - ready_o high again after edge k+10, so the next accept is at edge k+11 at the earliest.
  - Each en=0 cycle during ROUND adds one cycle of latency.
- round_key_i must be stable from accept through the final round; changing it mid-block gives undefined plaintext but no lock-up.
- Reset asserted mid-block aborts the block with no valid_o pulse; all outputs return to their reset values immediately.
- Counter width is 4 bits; rnd never wraps below 0.

Test Plan:
1. FIPS-197 C.1: key 000102030405060708090a0b0c0d0e0f (rk[10]=13111d7fe3944a17f307a78b4d2b30c5), ciphertext_i=69c4e0d86a7b0430d8cdb78070b4c55a, en=1 -> one valid_o pulse 10 edges after accept, plaintext_o=00112233445566778899aabbccddeeff.
2. FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c (rk[10]=d014f9a8c9ee2589e13f0cc8b6630ca6), ciphertext_i=3925841d02dc09fbdc118597196a0b32 -> plaintext_o=3243f6a8885a308d313198a2e0370734.
3. Random en toggling (50%) during 5 back-to-back blocks -> 5 valid_o pulses in order with correct plaintexts. Latency equals 10 plus the number of en=0 cycles spent in ROUND. valid_o is never wider than one cycle.
4. Second valid_i asserted while ready_o=0 (3 cycles after accept) with a different ciphertext -> ignored; only the first block's result appears. The second is accepted only once ready_o=1 and valid_i is still asserted.
5. rst_n pulsed low at round 5 of a C.1 decrypt -> valid_o, plaintext_o go to 0 with no pulse, ready_o=1. A subsequent C.1 decrypt completes correctly.
6. Round-trip: 5 random plaintexts through the encryptor, outputs fed to this block with the same round keys -> all plaintexts recovered exactly, zero mismatches.
